// File: rtl/writeback_stage_module.sv
// Writeback stage: retires ALU/link results directly and runs word-aligned loads
// through a REQ/WAIT handshake before writing extracted data to the register file.
module writeback_stage_module (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_kind,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_result,
   input  logic [2:0]  in_funct3,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        rf_write_enable,
   output logic [4:0]  rf_write_address,
   output logic [31:0] rf_data_to_write,
   output logic        busy,
   output logic [4:0]  busy_rd,
   output logic        load_error,
   output logic [31:0] retired_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t      state_r;
   logic [1:0]  lane_r;
   logic [2:0]  funct3_r;
   logic [4:0]  busy_rd_r;
   logic [31:0] mem_addr_r;
   logic        rf_we_r;
   logic [4:0]  rf_addr_r;
   logic [31:0] rf_data_r;
   logic        load_error_r;
   logic [31:0] retired_r;
   logic        load_legal_s;
   logic [31:0] load_data_s;

   // Legal sizes only, and halfword/word accesses must be naturally aligned.
   function automatic logic load_is_legal(input logic [2:0] f3, input logic [1:0] lo);
      logic ok;
      case (f3)
         3'b000, 3'b100: ok = 1'b1;
         3'b001, 3'b101: ok = ~lo[0];
         3'b010:         ok = (lo == 2'b00);
         default:        ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Select the addressed byte/halfword lane and extend it to 32 bits.
   function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [2:0] f3);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'b00:   b = word[7:0];
         2'b01:   b = word[15:8];
         2'b10:   b = word[23:16];
         2'b11:   b = word[31:24];
         default: b = 8'd0;
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b100:  r = {24'd0, b};
         3'b101:  r = {16'd0, h};
         3'b010:  r = word;
         default: r = word;
      endcase
      return r;
   endfunction

   // Per-cycle decode of the incoming load and of the pending response.
   always_comb begin
      load_legal_s = load_is_legal(in_funct3, in_result[1:0]);
      load_data_s  = extract_load(mem_rsp_data, lane_r, funct3_r);
   end

   // Stage FSM with registered register-file, error and retire outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         lane_r       <= 2'd0;
         funct3_r     <= 3'd0;
         busy_rd_r    <= 5'd0;
         mem_addr_r   <= 32'd0;
         rf_we_r      <= 1'b0;
         rf_addr_r    <= 5'd0;
         rf_data_r    <= 32'd0;
         load_error_r <= 1'b0;
         retired_r    <= 32'd0;
      end else begin
         rf_we_r      <= 1'b0;
         load_error_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  case (in_kind)
                     2'b01: begin
                        rf_we_r   <= (in_rd != 5'd0);
                        rf_addr_r <= in_rd;
                        rf_data_r <= in_result;
                        retired_r <= retired_r + 32'd1;
                     end
                     2'b11: begin
                        rf_we_r   <= (in_rd != 5'd0);
                        rf_addr_r <= in_rd;
                        rf_data_r <= in_result + 32'd4;
                        retired_r <= retired_r + 32'd1;
                     end
                     2'b10: begin
                        if (load_legal_s) begin
                           lane_r     <= in_result[1:0];
                           funct3_r   <= in_funct3;
                           busy_rd_r  <= in_rd;
                           mem_addr_r <= {in_result[31:2], 2'b00};
                           state_r    <= ST_REQ;
                        end else begin
                           load_error_r <= 1'b1;
                        end
                     end
                     default: retired_r <= retired_r + 32'd1;
                  endcase
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_REQ: begin
               if (mem_req_ready) begin
                  state_r <= ST_WAIT;
               end else begin
                  state_r <= ST_REQ;
               end
            end
            ST_WAIT: begin
               if (mem_rsp_valid) begin
                  rf_we_r   <= (busy_rd_r != 5'd0);
                  rf_addr_r <= busy_rd_r;
                  rf_data_r <= load_data_s;
                  retired_r <= retired_r + 32'd1;
                  busy_rd_r <= 5'd0;
                  state_r   <= ST_IDLE;
               end else begin
                  state_r <= ST_WAIT;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   assign in_ready         = (state_r == ST_IDLE);
   assign mem_req_valid    = (state_r == ST_REQ);
   assign busy             = (state_r != ST_IDLE);
   assign busy_rd          = busy_rd_r;
   assign mem_addr         = mem_addr_r;
   assign rf_write_enable  = rf_we_r;
   assign rf_write_address = rf_addr_r;
   assign rf_data_to_write = rf_data_r;
   assign load_error       = load_error_r;
   assign retired_count    = retired_r;

endmodule

// File: tb/tb_writeback_stage_module.sv
// Directed-vector bench for writeback_stage_module with hand-computed expectations.
module tb_writeback_stage_module;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_kind;
   logic [4:0]  in_rd;
   logic [31:0] in_result;
   logic [2:0]  in_funct3;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        rf_write_enable;
   logic [4:0]  rf_write_address;
   logic [31:0] rf_data_to_write;
   logic        busy;
   logic [4:0]  busy_rd;
   logic        load_error;
   logic [31:0] retired_count;

   int          vec_cnt = 0;
   int          err_cnt = 0;
   logic [31:0] exp_ret = 32'd0;

   writeback_stage_module dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
      .in_rd(in_rd), .in_result(in_result), .in_funct3(in_funct3),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .rf_write_enable(rf_write_enable), .rf_write_address(rf_write_address),
      .rf_data_to_write(rf_data_to_write), .busy(busy), .busy_rd(busy_rd),
      .load_error(load_error), .retired_count(retired_count)
   );

   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_vec({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
      check_vec({tag, " req_valid"}, {31'd0, mem_req_valid}, 32'd0);
      check_vec({tag, " busy"}, {31'd0, busy}, 32'd0);
      check_vec({tag, " busy_rd"}, {27'd0, busy_rd}, 32'd0);
      check_vec({tag, " retired"}, retired_count, exp_ret);
   endtask

   task automatic issue(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] res,
                        input logic [2:0] f3);
      in_valid  = 1'b1;
      in_kind   = kind;
      in_rd     = rd;
      in_result = res;
      in_funct3 = f3;
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic check_write(input string tag, input logic we, input logic [4:0] rd,
                              input logic [31:0] data);
      check_vec({tag, " we"}, {31'd0, rf_write_enable}, {31'd0, we});
      if (we) begin
         check_vec({tag, " waddr"}, {27'd0, rf_write_address}, {27'd0, rd});
         check_vec({tag, " wdata"}, rf_data_to_write, data);
      end
      check_vec({tag, " retired"}, retired_count, exp_ret);
   endtask

   task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [31:0] word, input logic [31:0] exp_data,
                          input int req_stall, input int rsp_delay);
      issue(2'b10, rd, addr, f3);
      for (int i = 0; i <= req_stall; i++) begin
         check_vec({tag, " req_valid"}, {31'd0, mem_req_valid}, 32'd1);
         check_vec({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
         check_vec({tag, " busy_rd"}, {26'd0, busy, busy_rd}, {26'd0, 1'b1, rd});
         check_vec({tag, " in_ready"}, {31'd0, in_ready}, 32'd0);
         mem_req_ready = (i == req_stall);
         tick();
      end
      mem_req_ready = 1'b0;
      for (int i = 0; i <= rsp_delay; i++) begin
         check_vec({tag, " wait req"}, {31'd0, mem_req_valid}, 32'd0);
         check_vec({tag, " wait busy"}, {26'd0, busy, busy_rd}, {26'd0, 1'b1, rd});
         check_vec({tag, " wait rdy"}, {30'd0, in_ready, rf_write_enable}, 32'd0);
         mem_rsp_valid = (i == rsp_delay);
         mem_rsp_data  = word;
         tick();
      end
      mem_rsp_valid = 1'b0;
      exp_ret = exp_ret + 32'd1;
      check_write(tag, (rd != 5'd0), rd, exp_data);
      check_idle_outputs(tag);
   endtask

   task automatic do_bad(input string tag, input logic [31:0] addr, input logic [2:0] f3);
      issue(2'b10, 5'd3, addr, f3);
      check_vec({tag, " err"}, {31'd0, load_error}, 32'd1);
      check_write(tag, 1'b0, 5'd0, 32'd0);
      check_idle_outputs(tag);
      tick();
      check_vec({tag, " err clr"}, {30'd0, load_error, mem_req_valid}, 32'd0);
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_kind = 2'b00; in_rd = 5'd0; in_result = 32'd0;
      in_funct3 = 3'd0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0;
      tick(); tick();
      check_idle_outputs("reset");
      check_write("reset", 1'b0, 5'd0, 32'd0);
      check_vec("reset rf", {load_error, rf_write_address, rf_data_to_write[25:0]}, 32'd0);
      check_vec("reset addr", mem_addr, 32'd0);
      rst = 1'b1;
      tick();

      issue(2'b01, 5'd5, 32'hDEADBEEF, 3'd0);
      exp_ret = 32'd1;
      check_write("alu", 1'b1, 5'd5, 32'hDEADBEEF);
      issue(2'b11, 5'd1, 32'hFFFFFFFC, 3'd0);
      exp_ret = 32'd2;
      check_write("link", 1'b1, 5'd1, 32'h00000000);
      issue(2'b01, 5'd0, 32'h00001234, 3'd0);
      exp_ret = 32'd3;
      check_write("alu rd0", 1'b0, 5'd0, 32'd0);
      issue(2'b00, 5'd6, 32'h00005555, 3'd0);
      exp_ret = 32'd4;
      check_write("kind none", 1'b0, 5'd0, 32'd0);
      tick();
      check_vec("we one cycle", {31'd0, rf_write_enable}, 32'd0);

      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFEF00D;
      tick();
      mem_rsp_valid = 1'b0;
      check_write("stray rsp", 1'b0, 5'd0, 32'd0);
      check_idle_outputs("stray rsp");

      do_load("lb", 32'h00001003, 3'b000, 5'd7, 32'h80FF7F01, 32'hFFFFFF80, 0, 0);
      do_load("lhu", 32'h00001002, 3'b101, 5'd8, 32'h80FF7F01, 32'h000080FF, 0, 0);
      do_load("lw", 32'h00001000, 3'b010, 5'd9, 32'h80FF7F01, 32'h80FF7F01, 4, 3);
      do_load("lh", 32'h00002000, 3'b001, 5'd10, 32'h00008001, 32'hFFFF8001, 1, 1);
      do_load("lbu", 32'h00002001, 3'b100, 5'd11, 32'h00008001, 32'h00000080, 0, 2);
      do_load("lb rd0", 32'h00002002, 3'b000, 5'd0, 32'h00FF0000, 32'hFFFFFFFF, 0, 0);

      do_bad("bad lh", 32'h00001001, 3'b001);
      do_bad("bad lw", 32'h00001002, 3'b010);
      do_bad("bad f3", 32'h00001000, 3'b011);
      do_bad("bad f3 7", 32'h00001000, 3'b111);

      issue(2'b10, 5'd12, 32'h00003004, 3'b010);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      check_vec("rst pre busy", {31'd0, busy}, 32'd1);
      rst = 1'b0;
      tick();
      exp_ret = 32'd0;
      check_idle_outputs("rst wait");
      check_write("rst wait", 1'b0, 5'd0, 32'd0);
      check_vec("rst wait addr", mem_addr, 32'd0);
      rst = 1'b1;
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h11223344;
      tick();
      mem_rsp_valid = 1'b0;
      check_write("late rsp", 1'b0, 5'd0, 32'd0);
      check_idle_outputs("late rsp");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/writeback_stage_module.md
# writeback_stage_module

Final pipeline stage of the core. It takes completed instructions from execute and issues word-aligned load requests to data memory. It extracts and extends the load data and drives the single write port of the 32x32 register file. It also reports the in-flight destination register for hazard detection and counts retired instructions.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  execute presents an instruction.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_kind  in  2  00 none, 01 ALU result, 10 load, 11 link (write in_result+4).
- in_rd  in  5  destination register.
- in_result  in  32  ALU result, load byte address, or PC for link.
- in_funct3  in  3  load size: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_req_valid  out  1  read request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  32  word address: {addr[31:2],2'b00}.
- mem_rsp_valid  in  1  read data valid, one-cycle pulse.
- mem_rsp_data  in  32  read word.
- rf_write_enable  out  1  register-file write strobe.
- rf_write_address  out  5  register-file write address.
- rf_data_to_write  out  32  register-file write data.
- busy  out  1  a load is in flight.
- busy_rd  out  5  destination of the in-flight load, 0 when not busy.
- load_error  out  1  one-cycle pulse for a misaligned load or an illegal funct3.
- retired_count  out  32  number of retired instructions, wraps modulo 2^32.

## Operation
- FSM states are IDLE, REQ and WAIT.
- in_ready = (state == IDLE). An instruction is accepted on an edge where in_valid && in_ready.
- IDLE, accept, kind 00/01/11:
  - Stay in IDLE, so back-to-back accepts are allowed.
  - Kind 01/11 sets rf_write_enable = (in_rd != 0), with data in_result or in_result+4 (mod 2^32).
  - Kind 00 writes nothing.
  - retired_count increments for all three kinds.
- IDLE, accept, kind 10:
  - A load is illegal if funct3 ∈ {011,110,111}, or if it is misaligned: LH/LHU with addr[0]=1, or LW with addr[1:0]≠0.
  - Illegal load: pulse load_error, no write, no retire, stay in IDLE.
  - Legal load: latch addr[1:0], funct3 and rd, then go to REQ.
- REQ:
  - mem_req_valid=1 and mem_addr is held stable.
  - Go to WAIT on the edge where mem_req_ready=1.
- WAIT:
  - mem_req_valid=0.
  - On mem_rsp_valid, extract the data and write it to rd (suppressed when rd=0), increment retired_count, return to IDLE.
- Load extraction:
  - Byte lane = addr[1:0]; halfword = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- busy=1 and busy_rd=latched rd in REQ and WAIT; otherwise busy=0 and busy_rd=0.
- mem_rsp_valid is ignored in IDLE and REQ (stray responses are dropped).

## Timing
- Reset values: state IDLE, in_ready=1, mem_req_valid=0, mem_addr=0, rf_write_enable=0, rf_write_address=0, rf_data_to_write=0, busy=0, busy_rd=0, load_error=0, retired_count=0.
- Reset takes effect at any state. A reset during REQ or WAIT abandons the load with no write and no retire. A response arriving after reset is ignored.
- rf_* outputs and load_error are registered:
  - They are valid in the cycle after the accepting edge (ALU/link), or after the mem_rsp_valid edge (load).
  - rf_write_enable is high for exactly one cycle per write and is 0 in every other cycle.
- ALU/link latency is 1 cycle; sustained throughput is 1 instruction per cycle.
- Load latency = 1 (REQ) + handshake wait + response wait + 1 (write). Minimum is accept edge N, request handshake N+1, response N+2, write visible in cycle N+3.
- in_ready returns to 1 in the cycle after the response edge, so a new accept can coincide with the load's write cycle.
- mem_req_valid is never dropped before mem_req_ready is seen.

## Test plan
- Reset, then ALU kind 01, rd=5, result 0xDEADBEEF -> next cycle rf_write_enable=1, address 5, data 0xDEADBEEF; retired_count=1.
- Link kind 11, rd=1, PC 0xFFFFFFFC -> data 0x00000000 (wrap); ALU write to rd=0 -> no strobe, retired_count still increments.
- LB at 0x1003, response 0x80FF7F01 -> data 0xFFFFFF80; LHU at 0x1002 -> 0x000080FF; LW at 0x1000 -> 0x80FF7F01; mem_addr=0x1000 in all three cases.
- LH at 0x1001, LW at 0x1002, funct3=011 -> load_error pulse each time, no mem_req_valid, no write, retired_count unchanged.
- mem_req_ready held 0 for 4 cycles, then response delayed 3 cycles -> mem_req_valid and mem_addr stable throughout; busy=1 and busy_rd=rd throughout; in_ready=0 until after the response.
- rst=0 asserted in WAIT, then mem_rsp_valid arrives -> no write; state IDLE; all outputs at their reset values; retired_count=0.
